// File: rtl/bool_identity_checker.sv
// Sequencer for the three-input Boolean-identity datapath: sweeps all eight
// (x,y,z) vectors, checks 19 identities per vector and reports sticky results.
module bool_identity_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [26:0] i_res,
  output logic        o_x,
  output logic        o_y,
  output logic        o_z,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [18:0] o_fail_mask,
  output logic [2:0]  o_first_fail_vec,
  output logic        o_first_fail_valid,
  output logic [2:0]  o_vec_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] S_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] FIRST  = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  vec;
  logic [18:0] f;
  logic        x;

  assign x = vec[2];

  always_comb begin
    f      = '0;
    f[0]   = i_res[0] ^ x;
    f[1]   = i_res[1];
    f[2]   = ~i_res[2];
    f[3]   = i_res[3] ^ x;
    f[4]   = ~i_res[4];
    f[5]   = i_res[5];
    f[6]   = i_res[6] ^ x;
    f[7]   = i_res[7] ^ x;
    f[8]   = i_res[8] ^ x;
    f[9]   = i_res[9]  ^ i_res[10];
    f[10]  = i_res[11] ^ i_res[12];
    f[11]  = i_res[13] ^ i_res[14];
    f[12]  = i_res[15] ^ i_res[16];
    f[13]  = i_res[17] ^ x;
    f[14]  = i_res[18] ^ x;
    f[15]  = i_res[19] ^ i_res[20];
    f[16]  = i_res[21] ^ i_res[22];
    f[17]  = i_res[23] ^ i_res[24];
    f[18]  = i_res[25] ^ i_res[26];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      vec                <= '0;
      o_pass             <= 1'b0;
      o_fail_mask        <= '0;
      o_first_fail_vec   <= '0;
      o_first_fail_valid <= 1'b0;
    end else begin
      case (state)
        // DONE behaves like IDLE so a start in the done cycle is accepted
        IDLE, DONE: begin
          vec <= '0;
          cnt <= '0;
          if (i_start && !i_abort) begin
            o_fail_mask        <= '0;
            o_first_fail_valid <= 1'b0;
            o_pass             <= 1'b0;
            state              <= FIRST;
          end else begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (i_abort) begin
            state              <= IDLE;
            vec                <= '0;
            o_fail_mask        <= '0;
            o_first_fail_valid <= 1'b0;
            o_pass             <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == S_LAST) state <= CHECK;
          end
        end
        CHECK: begin
          if (i_abort) begin
            state              <= IDLE;
            vec                <= '0;
            o_fail_mask        <= '0;
            o_first_fail_valid <= 1'b0;
            o_pass             <= 1'b0;
          end else begin
            o_fail_mask <= o_fail_mask | f;
            if ((f != '0) && !o_first_fail_valid) begin
              o_first_fail_vec   <= vec;
              o_first_fail_valid <= 1'b1;
            end
            if (vec == 3'd7) begin
              state  <= DONE;
              o_pass <= ((o_fail_mask | f) == '0);
            end else begin
              vec   <= vec + 3'd1;
              cnt   <= '0;
              state <= FIRST;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy    = (state == SETTLE) || (state == CHECK);
  assign o_done    = (state == DONE);
  assign o_x       = vec[2];
  assign o_y       = vec[1];
  assign o_z       = vec[0];
  assign o_vec_cnt = vec;

endmodule

// File: tb/tb_bool_identity_checker.sv
// Bench for bool_identity_checker: an S=2 and an S=0 instance share stimulus,
// each compared every cycle to a run-time/vector-index model of the sweep.
module tb_bool_identity_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort;
  int   fault_mode;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   e0 = 0;
  int   d0_done_cyc = -1;

  logic [26:0] res2, res0;
  logic x2, y2, z2, busy2, done2, pass2, ffv2;
  logic x0, y0, z0, busy0, done0, pass0, ffv0;
  logic [18:0] mask2, mask0;
  logic [2:0]  ffvec2, ffvec0, vcnt2, vcnt0;

  bool_identity_checker #(.SETTLE_CYCLES(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_res(res2),
    .o_x(x2), .o_y(y2), .o_z(z2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_fail_mask(mask2), .o_first_fail_vec(ffvec2), .o_first_fail_valid(ffv2),
    .o_vec_cnt(vcnt2));

  bool_identity_checker #(.SETTLE_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_res(res0),
    .o_x(x0), .o_y(y0), .o_z(z0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_fail_mask(mask0), .o_first_fail_vec(ffvec0), .o_first_fail_valid(ffv0),
    .o_vec_cnt(vcnt0));

  // Ideal datapath: every identity holds for every vector.
  function automatic logic [26:0] ideal(input logic [2:0] v);
    logic a, b, c;
    logic [26:0] r;
    a = v[2]; b = v[1]; c = v[0];
    r = '0;
    r[0] = a; r[1] = 1'b0; r[2] = 1'b1; r[3] = a; r[4] = 1'b1; r[5] = 1'b0;
    r[6] = a; r[7] = a; r[8] = a;
    r[9]  = a & b;        r[10] = b & a;
    r[11] = a | b;        r[12] = b | a;
    r[13] = a ^ c;        r[14] = c ^ a;
    r[15] = b & c;        r[16] = c & b;
    r[17] = a;            r[18] = a;
    r[19] = ~a;           r[20] = ~a;
    r[21] = a | b | c;    r[22] = c | b | a;
    r[23] = (a & b) | c;  r[24] = (a | c) & (b | c);
    r[25] = ~(b ^ c);     r[26] = (b & c) | (~b & ~c);
    return r;
  endfunction

  function automatic logic [26:0] datapath(input logic [2:0] v, input int mode);
    logic [26:0] r;
    r = ideal(v);
    if (mode == 1) r[1] = 1'b1;
    if (mode == 2 && v == 3'd5) r[10] = ~r[10];
    return r;
  endfunction

  assign res2 = datapath({x2, y2, z2}, fault_mode);
  assign res0 = datapath({x0, y0, z0}, fault_mode);

  // Identity rules: first nine compare a result with x or a constant,
  // the rest compare adjacent result pairs or a result with x.
  function automatic logic [18:0] exp_f(input logic [26:0] r, input logic [2:0] v);
    logic [8:0]  uses_x;
    logic [8:0]  const_v;
    logic [18:0] e;
    uses_x  = 9'b111001001;
    const_v = 9'b000010100;
    e = '0;
    for (int i = 0; i < 9; i++)
      e[i] = (r[i] != (uses_x[i] ? v[2] : const_v[i]));
    for (int j = 0; j < 4; j++) begin
      e[9 + j]  = (r[9 + 2*j]  != r[10 + 2*j]);
      e[15 + j] = (r[19 + 2*j] != r[20 + 2*j]);
    end
    e[13] = (r[17] != v[2]);
    e[14] = (r[18] != v[2]);
    return e;
  endfunction

  typedef struct {
    bit          active;
    int          t;
    logic [18:0] mask;
    bit          ffv;
    logic [2:0]  ffvec;
    bit          pass;
    bit          done;
  } mdl_t;

  // Run modelled as elapsed cycle t: vector = t/(S+1), check when t%(S+1)==S.
  function automatic mdl_t step(input mdl_t m, input int s, input logic st,
                                input logic ab, input logic [26:0] r);
    int v;
    logic [18:0] e;
    if (m.active) begin
      if (ab) begin
        m.active = 0; m.mask = '0; m.ffv = 0; m.pass = 0; m.done = 0;
      end else begin
        v = m.t / (s + 1);
        if (m.t % (s + 1) == s) begin
          e = exp_f(r, v[2:0]);
          m.mask = m.mask | e;
          if (e != '0 && !m.ffv) begin m.ffv = 1; m.ffvec = v[2:0]; end
          if (v == 7) begin
            m.active = 0; m.done = 1; m.pass = (m.mask == '0);
          end
        end
        m.t++;
      end
    end else begin
      m.done = 0;
      if (st && !ab) begin
        m.active = 1; m.t = 0; m.mask = '0; m.ffv = 0; m.pass = 0;
      end
    end
    return m;
  endfunction

  function automatic int mvec(input mdl_t m, input int s);
    if (m.active) return m.t / (s + 1);
    return m.done ? 7 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  mdl_t m2, m0;
  logic        cs_start, cs_abort;
  logic [26:0] cs_res2, cs_res0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2 = '{default: 0};
      m0 = '{default: 0};
    end else begin
      m2 = step(m2, 2, cs_start, cs_abort, cs_res2);
      m0 = step(m0, 0, cs_start, cs_abort, cs_res0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy2", 32'(busy2), 32'(m2.active));
      chk("done2", 32'(done2), 32'(m2.done));
      chk("pass2", 32'(pass2), 32'(m2.pass));
      chk("mask2", 32'(mask2), 32'(m2.mask));
      chk("ffv2",  32'(ffv2),  32'(m2.ffv));
      if (m2.ffv) chk("ffvec2", 32'(ffvec2), 32'(m2.ffvec));
      chk("vec2",  32'(vcnt2), 32'(mvec(m2, 2)));
      chk("xyz2",  32'({x2, y2, z2}), 32'(mvec(m2, 2)));
      chk("busy0", 32'(busy0), 32'(m0.active));
      chk("done0", 32'(done0), 32'(m0.done));
      chk("pass0", 32'(pass0), 32'(m0.pass));
      chk("mask0", 32'(mask0), 32'(m0.mask));
      chk("ffv0",  32'(ffv0),  32'(m0.ffv));
      if (m0.ffv) chk("ffvec0", 32'(ffvec0), 32'(m0.ffvec));
      chk("vec0",  32'(vcnt0), 32'(mvec(m0, 0)));
      chk("xyz0",  32'({x0, y0, z0}), 32'(mvec(m0, 0)));
      if (done0) d0_done_cyc = cyc;
    end
    cs_start = start;
    cs_abort = abort;
    cs_res2  = res2;
    cs_res0  = res0;
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #1 e0 = cyc;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done2) begin n = cyc - e0; return; end
    end
  endtask

  task automatic wait_vec(input logic [2:0] v);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy2 && vcnt2 == v) return;
    end
    chk("wait_vec_timeout", 32'(vcnt2), 32'(v));
  endtask

  initial begin
    int n;
    int dcount;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fault_mode = 0;
    #12;
    chk("rst_busy", 32'(busy2), 0);
    chk("rst_mask", 32'(mask2), 0);
    chk("rst_vec",  32'(vcnt2), 0);
    chk("rst_pass", 32'(pass2), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Ideal run
    pulse_start();
    wait_done(n);
    chk("t1_done_edge", 32'(n), 24);
    chk("t1_pass", 32'(pass2), 1);
    chk("t1_mask", 32'(mask2), 0);
    chk("t1_ffv",  32'(ffv2), 0);
    chk("t1_s0_done_edge", 32'(d0_done_cyc - e0), 8);
    chk("t1_s0_pass", 32'(pass0), 1);

    // r2 stuck at 1
    fault_mode = 1;
    pulse_start();
    wait_done(n);
    chk("t2_done_edge", 32'(n), 24);
    chk("t2_mask",  32'(mask2), 32'h00002);
    chk("t2_ffv",   32'(ffv2), 1);
    chk("t2_ffvec", 32'(ffvec2), 0);
    chk("t2_pass",  32'(pass2), 0);
    chk("t2_s0_mask", 32'(mask0), 32'h00002);

    // Start during the DONE cycle, r11 inverted at vector 5
    fault_mode = 2;
    #1 start = 1'b1;
    @(posedge clk); #1 e0 = cyc;
    chk("t3_mask_cleared", 32'(mask2), 0);
    chk("t3_busy", 32'(busy2), 1);
    #1 start = 1'b0;
    wait_done(n);
    chk("t3_done_edge", 32'(n), 24);
    chk("t3_mask",  32'(mask2), 32'h00200);
    chk("t3_ffvec", 32'(ffvec2), 5);
    chk("t3_pass",  32'(pass2), 0);

    // Abort at vector 3 in SETTLE, with a simultaneous start
    fault_mode = 0;
    pulse_start();
    wait_vec(3'd3);
    #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    chk("t4_busy", 32'(busy2), 0);
    chk("t4_xyz",  32'({x2, y2, z2}), 0);
    chk("t4_mask", 32'(mask2), 0);
    #1 start = 1'b0; abort = 1'b0;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done2 || busy2) dcount++;
    end
    chk("t4_no_done", 32'(dcount), 0);

    // Start while busy at vector 4 is ignored
    pulse_start();
    wait_vec(3'd4);
    #1 start = 1'b1;
    @(posedge clk); #1;
    chk("t5_busy", 32'(busy2), 1);
    #1 start = 1'b0;
    wait_done(n);
    chk("t5_done_edge", 32'(n), 24);
    chk("t5_pass", 32'(pass2), 1);

    // Async reset mid-run at vector 6
    fault_mode = 1;
    pulse_start();
    wait_vec(3'd6);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy2), 0);
    chk("t6_done", 32'(done2), 0);
    chk("t6_mask", 32'(mask2), 0);
    chk("t6_ffv",  32'(ffv2), 0);
    chk("t6_ffvec", 32'(ffvec2), 0);
    chk("t6_xyz",  32'({x2, y2, z2, vcnt2}), 0);
    chk("t6_pass", 32'(pass2), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    fault_mode = 0;
    pulse_start();
    wait_done(n);
    chk("t7_done_edge", 32'(n), 24);
    chk("t7_pass", 32'(pass2), 1);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
